fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of producer requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data width; it matches the shared sync FIFO wdata width.
REQ-003 SHALL have parameter BURST, default 4, maximum accepted beats per grant tenure (1..16).
REQ-004 SHALL have port: clk_i  in  1  single clock, all logic on the posedge.
REQ-005 SHALL have port: rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port: req_i  in  NREQ  per-requester write request, held while data is valid.
REQ-007 SHALL have port: data_i  in  NREQ*WIDTH  flattened requester data, requester k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port: fifo_full_i  in  1  full flag from the shared FIFO.
REQ-009 SHALL have port: gnt_o  out  NREQ  registered one-hot grant (all-zero when idle).
REQ-010 SHALL have port: ack_o  out  NREQ  per-requester beat accepted this cycle; the requester advances its data on ack.
REQ-011 SHALL have port: fifo_wr_en_o  out  1  FIFO write enable.
REQ-012 SHALL have port: fifo_wdata_o  out  WIDTH  FIFO write data.
REQ-013 SHALL have port: busy_o  out  1  high while in GRANT.

Function
REQ-014 SHALL implement FSM states IDLE and GRANT, with a registered owner index, a last-winner index and a beat counter of width $clog2(BURST+1).
REQ-015 SHALL, in IDLE with any req_i bit high, select the first requesting index scanning cyclically from last_winner+1, load it as owner, set gnt_o one-hot for it, clear beat_cnt, and enter GRANT on the next edge.
REQ-016 SHALL stay in IDLE with gnt_o=0 when req_i=0.
REQ-017 SHALL, in GRANT, combinationally assert ack_o[owner]=fifo_wr_en_o=req_i[owner] & ~fifo_full_i; all other ack_o bits are 0.
REQ-018 SHALL drive fifo_wdata_o = data_i slice of owner whenever in GRANT, and 0 in IDLE.
REQ-019 SHALL increment beat_cnt only on an accepted beat; a cycle with fifo_full_i=1 stalls without counting and without releasing the grant.
REQ-020 SHALL release the grant when req_i[owner]=0, or when an accepted beat brings beat_cnt to BURST; on release, last_winner becomes owner.
REQ-021 SHALL, on release, re-arbitrate in the same cycle with last_winner := owner; if another request is pending (owner excluded unless it is the only requester), the next owner is granted at the next edge with no idle bubble; otherwise the FSM returns to IDLE.
REQ-022 SHALL, when the owner is the only requester at a BURST release, regrant it at the next edge with beat_cnt cleared.
REQ-023 SHALL never assert fifo_wr_en_o while fifo_full_i=1, and never assert more than one gnt_o or ack_o bit.
REQ-024 SHALL guarantee each continuously requesting requester a grant within NREQ-1 tenures.

Reset
REQ-025 SHALL, when rst_i=1 at a posedge, set state=IDLE, gnt_o=0, owner=0, beat_cnt=0, last_winner=NREQ-1 (so requester 0 wins first), and busy_o=0; ack_o and fifo_wr_en_o are then 0.
REQ-026 SHALL abandon the tenure when reset is asserted mid-GRANT; no write is issued in the reset cycle.

Structure
REQ-027 SHALL place the FSM state encoding and the default NREQ/WIDTH/BURST constants in the shared fifo package, for reuse by the sync FIFO bench.
REQ-028 SHALL implement the cyclic priority pick as one sub-module, rr_pick (inputs: req vector and last index; outputs: valid and index), instantiated once.

Verification
REQ-029 SHALL check: reset, then req_i=4'b0001 held with full=0 -> gnt_o=0001 one cycle later, 4 acks with data 0x11..0x14 written, release at beat 4, and regrant to 0 on the next cycle.
REQ-030 SHALL check: req_i=4'b1111 held for 40 cycles -> tenures rotate in order 0,1,2,3,0, each of 4 beats, with no idle cycle between tenures.
REQ-031 SHALL check: owner 2 mid-burst with fifo_full_i=1 for 3 cycles -> fifo_wr_en_o=0 and ack_o=0 for those 3 cycles, beat_cnt unchanged, and the burst completes its remaining beats after full drops.
REQ-032 SHALL check: owner 1 drops req after 2 beats while req_i[3]=1 -> gnt_o=1000 on the next cycle.
REQ-033 SHALL check: rst_i pulsed while in GRANT with req=4'b0110 -> gnt_o=0 and no write that cycle, then requester 1 is granted first after reset.
REQ-034 SHALL check, with an integrated sync FIFO (DEPTH 16), 4 requesters and 64 beats total -> FIFO contents match the arbitration order, and no write occurs while full.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and FSM encoding for the FIFO write arbiter
// and the sync FIFO it feeds.
package fifo_wr_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_BURST = 4;
    localparam int DEF_DEPTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic priority pick: first set bit of req_i scanning
// upward from last_i+1, wrapping; last_i itself is checked last.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    logic          w_valid;
    logic [IW-1:0] w_idx;

    always_comb begin
        w_valid = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (int'(last_i) + i) % NREQ;
            if (!w_valid && req_i[c]) begin
                w_valid = 1'b1;
                w_idx   = IW'(c);
            end
        end
    end

    assign valid_o = w_valid;
    assign idx_o   = w_idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N producers share one sync FIFO
// write port, each tenure capped at BURST accepted beats.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int BURST = DEF_BURST
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] data_i,
    input  logic                  fifo_full_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       ack_o,
    output logic                  fifo_wr_en_o,
    output logic [WIDTH-1:0]      fifo_wdata_o,
    output logic                  busy_o
);

    localparam int IW = idx_w(NREQ);
    localparam int BW = $clog2(BURST + 1);

    arb_state_t      r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [BW-1:0]   r_beat;
    logic [NREQ-1:0] r_gnt;

    logic            w_grant;
    logic            w_wr;
    logic            w_release;
    logic [IW-1:0]   w_pick_last;
    logic            w_pick_vld;
    logic [IW-1:0]   w_pick_idx;
    logic [NREQ-1:0] w_onehot;

    assign w_grant     = (r_state == ST_GRANT);
    assign w_pick_last = w_grant ? r_owner : r_last;

    // A beat is never issued in a reset cycle, even mid-tenure.
    assign w_wr = w_grant & req_i[r_owner] & ~fifo_full_i & ~rst_i;

    assign w_release = w_grant &
        (~req_i[r_owner] | (w_wr & (r_beat == BW'(BURST - 1))));

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (w_pick_last),
        .valid_o (w_pick_vld),
        .idx_o   (w_pick_idx)
    );

    always_comb begin
        w_onehot = '0;
        w_onehot[w_pick_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_last  <= IW'(NREQ - 1);
            r_beat  <= '0;
            r_gnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick_idx;
                        r_gnt   <= w_onehot;
                        r_beat  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_last <= r_owner;
                        if (w_pick_vld) begin
                            r_owner <= w_pick_idx;
                            r_gnt   <= w_onehot;
                            r_beat  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                        end
                    end else if (w_wr) begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ack_o = '0;
        ack_o[r_owner] = w_wr;
    end

    assign gnt_o        = r_gnt;
    assign busy_o       = w_grant;
    assign fifo_wr_en_o = w_wr;
    assign fifo_wdata_o = w_grant ?
        data_i[int'(r_owner)*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run into a modelled 16-deep sync FIFO.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic                  full;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       ack_o;
    logic                  wr_o;
    logic [WIDTH-1:0]      wd_o;
    logic                  busy_o;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .BURST (BURST)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .data_i       (data),
        .fifo_full_i  (full),
        .gnt_o        (gnt_o),
        .ack_o        (ack_o),
        .fifo_wr_en_o (wr_o),
        .fifo_wdata_o (wd_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [NREQ-1:0]  ack;
        logic             wr;
        logic [WIDTH-1:0] wd;
        logic             busy;
    } exp_t;

    exp_t             exq[$];
    logic [WIDTH-1:0] exp_order[$];
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] seen[$];

    int checks = 0;
    int fails  = 0;

    // stimulus state
    logic             rst_v  = 1'b1;
    logic             full_v = 1'b0;
    int               rem[NREQ];
    logic [WIDTH-1:0] dat[NREQ];
    bit               fifo_mode = 1'b0;

    // reference model: tenure-level arbitration state
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = NREQ - 1;
    int m_beat  = 0;

    function automatic int pick(int last, logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++)
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    function automatic bit all_done();
        for (int k = 0; k < NREQ; k++)
            if (rem[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain_one();
        logic [WIDTH-1:0] a;
        a = fifo_q.pop_front();
        seen.push_back(a);
        checks++;
        if (exp_order.size() == 0) begin
            fails++;
            $display("FAIL fifo_order got %h want <none>", a);
        end else if (a !== exp_order[0]) begin
            fails++;
            $display("FAIL fifo_order got %h want %h", a, exp_order[0]);
            void'(exp_order.pop_front());
        end else begin
            void'(exp_order.pop_front());
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] rv;
        exp_t e;
        bit   wr;
        int   o;
        @(posedge clk);
        #1;
        if (fifo_mode) begin
            if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0)
                drain_one();
            full_v = (fifo_q.size() >= DEPTH);
        end
        for (int k = 0; k < NREQ; k++) rv[k] = (rem[k] > 0);
        rst  = rst_v;
        req  = rv;
        full = full_v;
        data = {dat[3], dat[2], dat[1], dat[0]};
        o  = m_owner;
        wr = m_busy && rv[o] && !full_v && !rst_v;
        e.gnt  = m_busy ? NREQ'(1) << o : '0;
        e.ack  = wr ? NREQ'(1) << o : '0;
        e.wr   = wr;
        e.wd   = m_busy ? dat[o] : '0;
        e.busy = m_busy;
        exq.push_back(e);
        if (wr) exp_order.push_back(dat[o]);
        if (rst_v) begin
            m_busy = 0; m_owner = 0; m_beat = 0; m_last = NREQ - 1;
        end else if (!m_busy) begin
            if (rv != 0) begin
                m_owner = pick(m_last, rv); m_busy = 1; m_beat = 0;
            end
        end else begin
            if (wr) m_beat++;
            if (!rv[o] || m_beat == BURST) begin
                m_last = o;
                if (rv != 0) begin
                    m_owner = pick(m_last, rv); m_beat = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
        if (wr) begin
            dat[o] = dat[o] + 8'd1;
            rem[o] = rem[o] - 1;
        end
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        for (int k = 0; k < NREQ; k++) rem[k] = 0;
        rst_v = 1'b1;
        steps(2);
        rst_v = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk);
        #1;
        checks++;
        if (fifo_q.size() != exp_order.size()) begin
            fails++;
            $display("FAIL write_count got %0d want %0d",
                     fifo_q.size(), exp_order.size());
        end
        while (fifo_q.size() > 0 && exp_order.size() > 0) drain_one();
        fifo_q.delete();
        exp_order.delete();
    endtask

    // monitor: compare every cycle, capture writes into the FIFO model
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exq.size() > 0) begin
                e = exq.pop_front();
                checks++;
                if ({gnt_o, ack_o, wr_o, wd_o, busy_o} !==
                    {e.gnt, e.ack, e.wr, e.wd, e.busy}) begin
                    fails++;
                    $display("FAIL outputs t=%0t got gnt=%b ack=%b wr=%b wd=%h busy=%b want gnt=%b ack=%b wr=%b wd=%h busy=%b",
                             $time, gnt_o, ack_o, wr_o, wd_o, busy_o,
                             e.gnt, e.ack, e.wr, e.wd, e.busy);
                end
                if (wr_o === 1'b1) begin
                    if (fifo_mode) begin
                        checks++;
                        if (fifo_q.size() >= DEPTH || full !== 1'b0) begin
                            fails++;
                            $display("FAIL write_while_full got level=%0d want <%0d",
                                     fifo_q.size(), DEPTH);
                        end
                    end
                    fifo_q.push_back(wd_o);
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] b[NREQ];
        int budget, cyc, k, n, t, r;
        rst  = 1'b1;
        req  = '0;
        data = '0;
        full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            dat[i] = 8'h00;
        end

        // single requester: 4-beat bursts, back-to-back regrant
        do_reset();
        dat[0] = 8'h11;
        seen.delete();
        rem[0] = 1000;
        steps(12);
        rem[0] = 0;
        steps(2);
        flush();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seen.size() <= i || seen[i] !== 8'h11 + 8'(i)) begin
                fails++;
                $display("FAIL solo_data[%0d] got %h want %h", i,
                         (seen.size() > i) ? seen[i] : 8'hxx, 8'h11 + 8'(i));
            end
        end

        // all four requesting: rotation 0,1,2,3,0 of 4 beats each
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = 8'(8'h20 + 8'h20 * i);
            b[i] = dat[i];
            rem[i] = 1000;
        end
        seen.delete();
        steps(40);
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        steps(2);
        flush();
        for (int i = 0; i < 32; i++) begin
            t = i / BURST;
            r = t % NREQ;
            n = (t / NREQ) * BURST + i % BURST;
            checks++;
            if (seen.size() <= i || seen[i] !== b[r] + 8'(n)) begin
                fails++;
                $display("FAIL rotation[%0d] got %h want %h", i,
                         (seen.size() > i) ? seen[i] : 8'hxx, b[r] + 8'(n));
            end
        end

        // owner 2 stalled by full mid-burst
        do_reset();
        rem[2] = 8;
        steps(3);
        full_v = 1'b1;
        steps(3);
        full_v = 1'b0;
        steps(10);
        flush();

        // owner 1 drops after 2 beats, requester 3 waiting
        do_reset();
        rem[1] = 2;
        rem[3] = 6;
        steps(14);
        flush();

        // reset pulse mid-tenure
        do_reset();
        rem[1] = 50;
        rem[2] = 50;
        steps(3);
        rst_v = 1'b1;
        steps(1);
        rst_v = 1'b0;
        steps(6);
        rem[1] = 0;
        rem[2] = 0;
        steps(2);
        flush();

        // random traffic, 64 beats into a 16-deep FIFO
        do_reset();
        seen.delete();
        fifo_mode = 1'b1;
        budget = 64;
        cyc = 0;
        while (!(budget == 0 && all_done()) && cyc < 3000) begin
            if (budget > 0 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, NREQ - 1);
                n = $urandom_range(1, 6);
                if (n > budget) n = budget;
                rem[k] += n;
                budget -= n;
            end
            step();
            cyc++;
        end
        checks++;
        if (cyc >= 3000) begin
            fails++;
            $display("FAIL random_timeout got cycles=%0d want <3000", cyc);
        end
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        fifo_mode = 1'b0;
        full_v = 1'b0;
        steps(2);
        flush();
        checks++;
        if (seen.size() != 64) begin
            fails++;
            $display("FAIL random_total got %0d want 64", seen.size());
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
